xnor_match_sched: RTL and testbench

- Round-robin scheduler that shares one bit-serial XNOR match engine among N requesters.
- Each requester presents two W-bit operands. The granted pair is compared one bit per cycle, LSB first; per bit, match = a XNOR b.
- Reports whole-word equality and a matching-bit count, tagged with the requester index.
- Sits between client blocks and the shared XNOR datapath: sequences it and arbitrates access to it.

---
 rtl/xnor_sched_pkg.sv | 36 +++
 rtl/xnor_match_sched_engine.sv | 89 ++++++++
 rtl/xnor_match_sched.sv | 136 +++++++++++++
 tb/tb_xnor_match_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/xnor_sched_pkg.sv
// Shared types and round-robin search helper for the XNOR match scheduler.
// Provides the FSM state enum and rr_pick(), used by xnor_match_sched.
package xnor_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int MAX_N  = 64;
   localparam int MAX_IW = 6;

   // First set bit of req scanning ptr, ptr+1, ... wrapping mod n.
   // Returns 0 when req is empty; callers only use it when |req.
   function automatic int rr_pick(
      input logic [MAX_N-1:0] req,
      input int               n,
      input int               ptr
   );
      int   idx;
      logic found;
      rr_pick = 0;
      found   = 1'b0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n) begin
            idx = (ptr + i) % n;
            if (!found && req[idx[MAX_IW-1:0]]) begin
               found   = 1'b1;
               rr_pick = idx;
            end
         end
      end
   endfunction

endpackage

// File: rtl/xnor_match_sched_engine.sv
// Bit-serial XNOR engine: operand shift registers, eq/count accumulators.
// Ports: load/shift controls, a_in/b_in, last flag, eq_fin/cnt_fin results.
// Count accumulator built only with XNOR_MATCH_CNT_EN; else cnt_fin = 0.
module xnor_bit_engine
   import xnor_sched_pkg::*;
#(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          shift,
   input  logic [W-1:0]  a_in,
   input  logic [W-1:0]  b_in,
   output logic          last,
   output logic          eq_fin,
   output logic [CW-1:0] cnt_fin
);

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          eq_q, eq_d;
   logic [CW-1:0] bit_q, bit_d;
   logic          m;

   assign m    = a_q[0] ~^ b_q[0];
   assign last = (bit_q == CW'(W - 1));

   // Results include the bit being consumed this cycle so the top can
   // latch them on the final shift edge.
   assign eq_fin = eq_q & m;

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      eq_d  = eq_q;
      bit_d = bit_q;
      if (load) begin
         a_d   = a_in;
         b_d   = b_in;
         eq_d  = 1'b1;
         bit_d = '0;
      end else if (shift) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         eq_d  = eq_fin;
         bit_d = last ? '0 : bit_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         eq_q  <= 1'b0;
         bit_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         eq_q  <= eq_d;
         bit_q <= bit_d;
      end
   end

`ifdef XNOR_MATCH_CNT_EN
   logic [CW-1:0] cnt_q, cnt_d;

   assign cnt_fin = cnt_q + CW'(m);

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = '0;
      else if (shift)
         cnt_d = cnt_fin;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
`else
   assign cnt_fin = '0;
`endif

endmodule

// File: rtl/xnor_match_sched.sv
// Round-robin scheduler sharing one bit-serial XNOR match engine among N.
// Ports: req/op_a/op_b in; gnt, busy, done, done_id, eq, match_cnt out.
// Optional macro XNOR_MATCH_CNT_EN builds the match counter.
module xnor_match_sched
   import xnor_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int W   = 8,
   parameter int IDW = $clog2(N),
   parameter int CW  = $clog2(W + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] op_a,
   input  logic [N*W-1:0] op_b,
   output logic [N-1:0]   gnt,
   output logic           busy,
   output logic           done,
   output logic [IDW-1:0] done_id,
   output logic           eq,
   output logic [CW-1:0]  match_cnt
);

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           done_q, done_d;
   logic [IDW-1:0] done_id_q, done_id_d;
   logic           eq_q, eq_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [MAX_N-1:0] req_ext;
   int               win_i;
   int               nxt_i;
   logic [IDW-1:0]   win;
   logic             load;
   logic             shift;
   logic             last;
   logic             eng_eq;
   logic [CW-1:0]    eng_cnt;

   assign req_ext = MAX_N'(req);

   always_comb begin
      win_i = rr_pick(req_ext, N, int'(ptr_q));
      nxt_i = (win_i + 1) % N;
      win   = win_i[IDW-1:0];
   end

   xnor_bit_engine #(
      .W  (W),
      .CW (CW)
   ) u_eng (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .a_in    (op_a[win*W +: W]),
      .b_in    (op_b[win*W +: W]),
      .last    (last),
      .eq_fin  (eng_eq),
      .cnt_fin (eng_cnt)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      eq_d      = eq_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      shift     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               load       = 1'b1;
               gnt_d[win] = 1'b1;
               id_d       = win;
               ptr_d      = nxt_i[IDW-1:0];
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            shift = 1'b1;
            if (last) begin
               state_d   = DONE;
               done_d    = 1'b1;
               done_id_d = id_q;
               eq_d      = eng_eq;
               cnt_d     = eng_cnt;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         eq_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         eq_q      <= eq_d;
         cnt_q     <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign done_id   = done_id_q;
   assign eq        = eq_q;
   assign match_cnt = cnt_q;

endmodule

// File: tb/tb_xnor_match_sched.sv
// Directed self-checking bench for xnor_match_sched (N=4, W=8).
// Expected match_cnt is 0 unless built with XNOR_MATCH_CNT_EN.
module tb_xnor_match_sched;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;
   localparam int CW  = 4;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] op_a;
   logic [N*W-1:0] op_b;
   logic [N-1:0]   gnt;
   logic           busy;
   logic           done;
   logic [IDW-1:0] done_id;
   logic           eq;
   logic [CW-1:0]  match_cnt;

   int n_chk;
   int n_pass;

   xnor_match_sched #(
      .N (N),
      .W (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .eq        (eq),
      .match_cnt (match_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a,
                         input logic [7:0] b);
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
   endtask

   function automatic int ecnt(input int c);
`ifdef XNOR_MATCH_CNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // Counts edges until done; reports the latency (999 if never seen).
   task automatic wait_done(input string tag, input int exp_lat);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < W + 4) begin
         tick();
         n++;
         if (done) seen = 1'b1;
      end
      chk(tag, seen ? n : 999, exp_lat);
   endtask

   task automatic xact(input string tag, input logic [N-1:0] r,
                       input int id, input int e, input int c);
      logic [N*W-1:0] sa;
      logic [N*W-1:0] sb;
      req = r;
      tick();
      chk({tag, "_gnt"}, int'(gnt), 1 << id);
      chk({tag, "_busy"}, int'(busy), 1);
      req = '0;
      sa   = op_a;
      sb   = op_b;
      op_a = ~sa;
      op_b = sa ^ 32'h1234_5678;
      wait_done({tag, "_lat"}, W);
      op_a = sa;
      op_b = sb;
      chk({tag, "_id"}, int'(done_id), id);
      chk({tag, "_eq"}, int'(eq), e);
      chk({tag, "_cnt"}, int'(match_cnt), ecnt(c));
      tick();
      chk({tag, "_idle"}, int'({busy, done}), 0);
   endtask

   initial begin
      int   exp_cnt [4];
      logic seen;
      n_chk   = 0;
      n_pass  = 0;
      rst     = 1'b1;
      req     = '0;
      op_a    = '0;
      op_b    = '0;
      tick();
      tick();
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_id", int'(done_id), 0);
      chk("rst_eq", int'(eq), 0);
      chk("rst_cnt", int'(match_cnt), 0);
      rst = 1'b0;
      tick();

      set_op(0, 8'hA5, 8'hA5);
      xact("s1", 4'b0001, 0, 1, 8);

      set_op(1, 8'hA5, 8'h5A);
      xact("s2a", 4'b0010, 1, 0, 0);
      set_op(1, 8'hF0, 8'hFF);
      xact("s2b", 4'b0010, 1, 0, 4);

      // ptr is 2; a grant to 3 brings it back to 0
      set_op(3, 8'h00, 8'h0F);
      xact("s3", 4'b1000, 3, 0, 4);

      set_op(0, 8'h00, 8'h00);
      set_op(1, 8'h00, 8'h01);
      set_op(2, 8'h00, 8'h03);
      set_op(3, 8'h00, 8'h0F);
      exp_cnt = '{8, 7, 6, 4};
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int id;
         id = k % 4;
         tick();
         chk("rr_gnt", int'(gnt), 1 << id);
         req[id] = 1'b0;
         tick();
         tick();
         req[id] = 1'b1;
         wait_done("rr_lat", W - 2);
         chk("rr_id", int'(done_id), id);
         chk("rr_eq", int'(eq), (id == 0) ? 1 : 0);
         chk("rr_cnt", int'(match_cnt), ecnt(exp_cnt[id]));
         tick();
      end
      req = '0;

      xact("w2", 4'b0100, 2, 0, 6);
      xact("wrap", 4'b0011, 0, 1, 8);

      // abort mid-shift; ptr would be 2 without the reset
      req = 4'b0010;
      tick();
      chk("ab_gnt", int'(gnt), 2);
      req = '0;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_busy", int'(busy), 0);
      chk("ab_done", int'(done), 0);
      chk("ab_id", int'(done_id), 0);
      chk("ab_eq", int'(eq), 0);
      chk("ab_cnt", int'(match_cnt), 0);
      chk("ab_gnt0", int'(gnt), 0);
      seen = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         if (done) seen = 1'b1;
      end
      chk("ab_nodone", int'(seen), 0);
      xact("ab_ptr", 4'b0101, 0, 1, 8);
      xact("ab_r2", 4'b0100, 2, 0, 6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
